// File: rtl/rf_dbg_pkg.sv
// rf_dbg_pkg: shared definitions for the register-file debug port.
//   rf_dbg_state_e : sequencer states (IDLE / LOAD / DUMP / FIN)
//   OP_LOAD/OP_DUMP: cmd_op encodings
//   RF_AW          : register-file address width used on the RF ports
package rf_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_FIN  = 2'd3
    } rf_dbg_state_e;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_DUMP = 1'b1;

    localparam int RF_AW = 5;

endpackage

// File: rtl/rf_dbg_outreg.sv
// rf_dbg_outreg: single-entry valid/ready holding register for the dump stream.
//   load              : capture in_data/in_idx and raise out_valid (caller only
//                       asserts it when can_load is high)
//   out_ready         : downstream accept; drains the entry when no new load
//   out_valid/data/idx: registered stream outputs, stable while stalled
//   can_load          : entry is empty or being drained this cycle
module rf_dbg_outreg
    import rf_dbg_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic [RF_AW-1:0] in_idx,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [RF_AW-1:0] out_idx,
    output logic             can_load
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [RF_AW-1:0] idx_q, idx_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            idx_d   = in_idx;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign can_load  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;

endmodule

// File: rtl/rf_debug_port.sv
// rf_debug_port: sequences a full register-file load from a stream (LOAD) or
// a full register-file dump onto a stream (DUMP), one command at a time.
//   cmd_valid/cmd_op/cmd_ready : command handshake, accepted only in IDLE
//   in_valid/in_ready/in_data  : load stream, written straight to the RF port
//   out_valid/out_ready/out_data/out_idx : dump stream with source index
//   rf_wr/rf_rd/rf_d           : RF write port (active only in LOAD)
//   rf_rn/rf_data1             : RF combinational read port (used in DUMP)
//   busy                       : not IDLE; done : one-cycle completion pulse
module rf_debug_port
    import rf_dbg_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic             cmd_op,
    output logic             cmd_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_idx,
    output logic [4:0]       rf_rd,
    output logic [WIDTH-1:0] rf_d,
    output logic             rf_wr,
    output logic [4:0]       rf_rn,
    input  logic [WIDTH-1:0] rf_data1,
    output logic             busy,
    output logic             done
);

    // idx must be able to hold NREGS so DUMP can tell "all reads issued".
    localparam int IW = $clog2(NREGS + 1);

    rf_dbg_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ld;
    logic          can_load;
    logic          out_last;

    rf_dbg_outreg #(.WIDTH(WIDTH)) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld),
        .in_data   (rf_data1),
        .in_idx    (RF_AW'(idx_q)),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .can_load  (can_load)
    );

    // Final dump beat leaving the holding register ends the command.
    assign out_last = out_valid && out_ready && (out_idx == RF_AW'(NREGS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        rf_wr     = 1'b0;
        rf_rd     = '0;
        rf_d      = '0;
        rf_rn     = '0;
        ld        = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    idx_d   = '0;
                    state_d = (cmd_op == OP_DUMP) ? ST_DUMP : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Write-through: the RF commits on the edge the beat is taken.
                in_ready = 1'b1;
                rf_wr    = in_valid;
                rf_rd    = RF_AW'(idx_q);
                rf_d     = in_data;
                if (in_valid) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(NREGS - 1)) state_d = ST_FIN;
                end
            end
            ST_DUMP: begin
                rf_rn = RF_AW'(idx_q);
                if (can_load && (idx_q < IW'(NREGS))) begin
                    ld    = 1'b1;
                    idx_d = idx_q + 1'b1;
                end
                if (out_last) state_d = ST_FIN;
            end
            ST_FIN: begin
                done    = 1'b1;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_rf_debug_port.sv
// tb_rf_debug_port: randomized self-checking bench for rf_debug_port.
// A behavioural RF array sits on the RF ports; the expected register contents
// are tracked in a separate model array updated from the words the bench sends.
module tb_rf_debug_port;

    localparam int NREGS = 32;
    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_op, cmd_ready;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       out_idx;
    logic [4:0]       rf_rd, rf_rn;
    logic [WIDTH-1:0] rf_d, rf_data1;
    logic             rf_wr, busy, done;

    logic [WIDTH-1:0] rf_mem [NREGS];
    logic [WIDTH-1:0] model  [NREGS];

    int n_cmp = 0;
    int n_err = 0;

    rf_debug_port #(.NREGS(NREGS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .rf_rd     (rf_rd),
        .rf_d      (rf_d),
        .rf_wr     (rf_wr),
        .rf_rn     (rf_rn),
        .rf_data1  (rf_data1),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_wr) rf_mem[rf_rd] <= rf_d;
    assign rf_data1 = rf_mem[rf_rn];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        chk("busy_idle", busy, 0);
        tick();
        cmd_valid = 1'b0;
    endtask

    // gap: 0 none, 1 valid every other cycle, 2 random. abort_n>0 resets after that many beats.
    task automatic do_load(input int gap, input bit fixed, input int abort_n);
        logic [WIDTH-1:0] vals [NREGS];
        int i, cyc, wrs;
        bit v;
        for (int k = 0; k < NREGS; k++)
            vals[k] = fixed ? 64'(64'h100 + k) : {$urandom, $urandom};
        issue_cmd(1'b0);
        i = 0; cyc = 0; wrs = 0;
        while (i < NREGS && cyc < 400) begin
            if (abort_n > 0 && i == abort_n) break;
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            in_valid = v;
            in_data  = v ? vals[i] : {$urandom, $urandom};
            #1;
            chk("load_in_ready", in_ready, 1);
            chk("load_rf_wr", rf_wr, v);
            if (rf_wr) wrs++;
            if (v) begin
                chk("load_rf_rd", rf_rd, i);
                chk("load_rf_d", rf_d, vals[i]);
                model[i] = vals[i];
                i++;
            end
            tick();
            cyc++;
        end
        if (abort_n > 0) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            rst_n    = 1'b0;
            #1;
            chk("abort_rf_wr", rf_wr, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_in_ready", in_ready, 0);
            tick();
            tick();
            rst_n    = 1'b1;
            in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                #1;
                chk("post_abort_done", done, 0);
                chk("post_abort_busy", busy, 0);
                tick();
            end
            return;
        end
        in_valid = 1'b0;
        #1;
        chk("load_beats", i, NREGS);
        chk("load_wr_count", wrs, NREGS);
        chk("load_done", done, 1);
        chk("load_fin_in_ready", in_ready, 0);
        tick();
        chk("load_done_pulse", done, 0);
        chk("load_busy_end", busy, 0);
    endtask

    // mode: 0 ready held, 1 ready pattern 1,0,0,1, 2 random. inject drives a command during DUMP.
    task automatic do_dump(input int mode, input bit inject);
        int e, cyc;
        bit r, held;
        logic [WIDTH-1:0] hdata;
        logic [4:0] hidx;
        logic [3:0] pat;
        pat = 4'b1001;
        issue_cmd(1'b1);
        e = 0; cyc = 0; held = 1'b0; hdata = '0; hidx = '0;
        while (e < NREGS && cyc < 600) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[3 - (cyc % 4)] : 1'($urandom_range(0, 1));
            out_ready = r;
            if (inject) begin
                cmd_valid = 1'b1;
                cmd_op    = 1'b0;
                in_valid  = 1'b1;
                in_data   = {$urandom, $urandom};
            end
            #1;
            if (inject) begin
                chk("dump_cmd_ready", cmd_ready, 0);
                chk("dump_rf_wr", rf_wr, 0);
            end
            if (held) chk("dump_valid_drop", out_valid, 1);
            if (out_valid) begin
                if (held) begin
                    chk("dump_stable_data", out_data, hdata);
                    chk("dump_stable_idx", out_idx, hidx);
                end
                if (r) begin
                    chk("dump_idx", out_idx, e);
                    chk("dump_data", out_data, model[e]);
                    e++;
                    held = 1'b0;
                end else begin
                    held  = 1'b1;
                    hdata = out_data;
                    hidx  = out_idx;
                end
            end
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("dump_beats", e, NREGS);
        if (mode == 0) chk("dump_cycles", cyc, NREGS + 1);
        #1;
        chk("dump_done", done, 1);
        chk("dump_valid_fall", out_valid, 0);
        tick();
        chk("dump_done_pulse", done, 0);
        chk("dump_busy_end", busy, 0);
        chk("dump_idle_ready", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            rf_mem[k] = '0;
            model[k]  = '0;
        end
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rf_wr", rf_wr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_rf_rn", rf_rn, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        tick();

        do_load(0, 1'b1, 0);
        do_dump(0, 1'b0);
        do_dump(1, 1'b0);
        do_load(1, 1'b0, 0);
        do_dump(2, 1'b1);
        do_load(2, 1'b0, 10);
        do_dump(0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            do_load(2, 1'b0, 0);
            do_dump(2, t == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
